// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of the register-file write port
// plus a per-register busy scoreboard. Optional forwarding of the write stage: WB_BYPASS_EN.
module regfile_wb_sched #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*5-1:0]    req_rd_i,
  input  logic [NREQ*XLEN-1:0] req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic                 rsv_en_i,
  input  logic [4:0]           rsv_rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic                 rs1_use_i,
  input  logic                 rs2_use_i,
  output logic                 stall_o,
`ifdef WB_BYPASS_EN
  output logic                 fwd1_o,
  output logic                 fwd2_o,
  output logic [XLEN-1:0]      fwd_data1_o,
  output logic [XLEN-1:0]      fwd_data2_o,
`endif
  output logic [4:0]           rsW_o,
  output logic [XLEN-1:0]      dataW_o,
  output logic                 RegWEn_o,
  output logic                 err_o
);

  localparam int PW = $clog2(NREQ);
  localparam int AW = $clog2(NREG);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            wen_q, wen_d;
  logic [4:0]      rsw_q, rsw_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx, idx;
  logic            found, xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            rsv_err, wr_err;
  logic            hit1, hit2;

  // Round-robin: first asserted valid at or after ptr wins; nothing is granted in reset.
  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_valid_i[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    xfer = found && !rst_i;
    if (xfer) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_rd   = req_rd_i[k*5 +: 5];
        sel_data = req_data_i[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    wen_d  = xfer && (sel_rd != 5'd0);
    rsw_d  = rsw_q;
    data_d = data_q;
    busy_d = busy_q;
    if (xfer) ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    // Writes to x0 complete the handshake but leave the write port idle.
    if (wen_d) begin
      rsw_d  = sel_rd;
      data_d = sel_data;
    end
    if (wen_q) busy_d[rsw_q[AW-1:0]] = 1'b0;
    if (rsv_en_i) busy_d[rsv_rd_i[AW-1:0]] = 1'b1;
    busy_d[0] = 1'b0;
    rsv_err = rsv_en_i && busy_q[rsv_rd_i[AW-1:0]] && !(wen_q && (rsw_q == rsv_rd_i));
    wr_err  = xfer && (sel_rd != 5'd0) && !busy_q[sel_rd[AW-1:0]];
    err_d   = err_q || rsv_err || wr_err;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      busy_q <= '0;
      wen_q  <= 1'b0;
      rsw_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      wen_q  <= wen_d;
      rsw_q  <= rsw_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

`ifdef WB_BYPASS_EN
  // A source matching the register written this cycle takes the write data instead of stalling.
  assign hit1        = wen_q && rs1_use_i && (rsw_q == rs1_i);
  assign hit2        = wen_q && rs2_use_i && (rsw_q == rs2_i);
  assign fwd1_o      = hit1;
  assign fwd2_o      = hit2;
  assign fwd_data1_o = data_q;
  assign fwd_data2_o = data_q;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign stall_o     = (rs1_use_i && busy_q[rs1_i[AW-1:0]] && !hit1) ||
                       (rs2_use_i && busy_q[rs2_i[AW-1:0]] && !hit2);
  assign req_ready_o = grant;
  assign rsW_o       = rsw_q;
  assign dataW_o     = data_q;
  assign RegWEn_o    = wen_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized and directed bench for regfile_wb_sched against a cycle-level reference model.
module tb_regfile_wb_sched;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NREQ-1:0]      valid;
  logic [4:0]           rd   [NREQ];
  logic [XLEN-1:0]      data [NREQ];
  logic [NREQ*5-1:0]    req_rd_i;
  logic [NREQ*XLEN-1:0] req_data_i;
  logic [NREQ-1:0]      req_ready_o;
  logic                 rsv_en_i;
  logic [4:0]           rsv_rd_i, rs1_i, rs2_i;
  logic                 rs1_use_i, rs2_use_i;
  logic                 stall_o;
  logic [4:0]           rsW_o;
  logic [XLEN-1:0]      dataW_o;
  logic                 RegWEn_o, err_o;
`ifdef WB_BYPASS_EN
  logic                 fwd1_o, fwd2_o;
  logic [XLEN-1:0]      fwd_data1_o, fwd_data2_o;
`endif

  always #5 clk_i = ~clk_i;

  always_comb begin
    req_rd_i   = '0;
    req_data_i = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_rd_i[k*5 +: 5]         = rd[k];
      req_data_i[k*XLEN +: XLEN] = data[k];
    end
  end

  regfile_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .NREG(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(valid), .req_rd_i(req_rd_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .rsv_en_i(rsv_en_i), .rsv_rd_i(rsv_rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_use_i(rs1_use_i), .rs2_use_i(rs2_use_i),
    .stall_o(stall_o),
`ifdef WB_BYPASS_EN
    .fwd1_o(fwd1_o), .fwd2_o(fwd2_o), .fwd_data1_o(fwd_data1_o), .fwd_data2_o(fwd_data2_o),
`endif
    .rsW_o(rsW_o), .dataW_o(dataW_o), .RegWEn_o(RegWEn_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state, updated once per rising edge.
  int              m_ptr;
  bit [31:0]       m_busy;
  bit              m_wen, m_err;
  bit [4:0]        m_rsw;
  bit [XLEN-1:0]   m_data;
  logic [NREQ-1:0] seen_rdy;
  logic            seen_stall;
  int              last_g;

  function automatic int model_grant();
    if (rst_i) return -1;
    for (int i = 0; i < NREQ; i++) begin
      int k = (m_ptr + i) % NREQ;
      if (valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit src_stall(input bit use_s, input bit [4:0] rs);
    bit s = use_s && m_busy[rs];
`ifdef WB_BYPASS_EN
    if (use_s && m_wen && m_rsw == rs) s = 1'b0;
`endif
    return s;
  endfunction

  task automatic model_edge(input int g);
    bit [4:0] wrd;
    if (rst_i) begin
      m_ptr = 0; m_busy = '0; m_wen = 0; m_rsw = '0; m_data = '0; m_err = 0;
      return;
    end
    if (rsv_en_i && m_busy[rsv_rd_i] && !(m_wen && m_rsw == rsv_rd_i)) m_err = 1;
    wrd = (g >= 0) ? rd[g] : 5'd0;
    if (g >= 0 && wrd != 0 && !m_busy[wrd]) m_err = 1;
    if (m_wen) m_busy[m_rsw] = 1'b0;
    if (rsv_en_i && rsv_rd_i != 0) m_busy[rsv_rd_i] = 1'b1;
    m_wen = (g >= 0) && (wrd != 0);
    if (m_wen) begin
      m_rsw  = wrd;
      m_data = data[g];
    end
    if (g >= 0) m_ptr = (g + 1) % NREQ;
  endtask

  // One clock: check combinational outputs before the edge, registered ones after it.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    seen_rdy   = req_ready_o;
    seen_stall = stall_o;
    check("ready", req_ready_o, exp_rdy);
    if (!rst_i) begin
      check("stall", stall_o, src_stall(rs1_use_i, rs1_i) | src_stall(rs2_use_i, rs2_i));
`ifdef WB_BYPASS_EN
      check("fwd1", fwd1_o, rs1_use_i && m_wen && m_rsw == rs1_i);
      if (fwd1_o) check("fwd_data1", fwd_data1_o, m_data);
`endif
    end
    last_g = g;
    @(posedge clk_i);
    model_edge(g);
    #1;
    check("RegWEn", RegWEn_o, m_wen);
    check("rsW", rsW_o, m_rsw);
    check("dataW", dataW_o, m_data);
    check("err", err_o, m_err);
  endtask

  task automatic idle_inputs();
    valid = '0; rsv_en_i = 0; rsv_rd_i = '0;
    rs1_i = '0; rs2_i = '0; rs1_use_i = 0; rs2_use_i = 0;
    for (int k = 0; k < NREQ; k++) begin rd[k] = '0; data[k] = '0; end
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_i = 1;
    cycle();
    cycle();
    rst_i = 0;
  endtask

  initial begin
    logic [NREQ-1:0] rr_seq [6];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset state and continuous round-robin with all requesters valid.
    reset_dut();
    check("reset_stall", stall_o, 1'b0);
    valid = 3'b111;
    for (int k = 0; k < NREQ; k++) begin rd[k] = 5'(k + 1); data[k] = 32'h100 + 32'(k); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_grant", seen_rdy, rr_seq[i]);
      check("rr_wen", RegWEn_o, 1'b1);
    end

    // Reserve x5, stall on it, LSU write-back clears the hazard.
    reset_dut();
    rsv_en_i = 1; rsv_rd_i = 5'd5;
    cycle();
    rsv_en_i = 0; rs1_i = 5'd5; rs1_use_i = 1;
    cycle();
    check("raw_stall", seen_stall, 1'b1);
    valid = 3'b010; rd[1] = 5'd5; data[1] = 32'hDEADBEEF;
    cycle();
    check("lsu_wen", RegWEn_o, 1'b1);
    check("lsu_rsw", rsW_o, 5'd5);
    check("lsu_data", dataW_o, 32'hDEADBEEF);
    valid = '0;
    cycle();
`ifdef WB_BYPASS_EN
    check("bypass_stall", seen_stall, 1'b0);
`else
    check("wb_edge_stall", seen_stall, 1'b1);
`endif
    cycle();
    check("post_wb_stall", seen_stall, 1'b0);
    check("no_err", err_o, 1'b0);

    // Write to x0: handshake completes, write port stays idle.
    rs1_use_i = 0;
    valid = 3'b001; rd[0] = 5'd0; data[0] = 32'h1234;
    cycle();
    check("x0_ready", seen_rdy, 3'b001);
    check("x0_wen", RegWEn_o, 1'b0);
    check("x0_err", err_o, 1'b0);

    // Reserve x7 on the edge that clears it: set wins, no error; a second reserve errs.
    valid = '0; rsv_en_i = 1; rsv_rd_i = 5'd7;
    cycle();
    rsv_en_i = 0; valid = 3'b001; rd[0] = 5'd7; data[0] = 32'h77;
    cycle();
    valid = '0; rsv_en_i = 1;
    cycle();
    check("rsv_clr_err", err_o, 1'b0);
    rsv_en_i = 0; rs1_i = 5'd7; rs1_use_i = 1;
    cycle();
    check("x7_busy", seen_stall, 1'b1);
    rsv_en_i = 1;
    cycle();
    check("dbl_rsv_err", err_o, 1'b1);
    rsv_en_i = 0;
    cycle();
    cycle();
    check("err_sticky", err_o, 1'b1);

    // Write without a reservation is flagged but still issued.
    reset_dut();
    valid = 3'b001; rd[0] = 5'd9; data[0] = 32'h99;
    cycle();
    check("norsv_err", err_o, 1'b1);
    check("norsv_wen", RegWEn_o, 1'b1);
    check("norsv_rsw", rsW_o, 5'd9);

    // Reset the cycle after a grant drops the write and clears ptr and scoreboard.
    reset_dut();
    rsv_en_i = 1; rsv_rd_i = 5'd3;
    cycle();
    rsv_en_i = 0; valid = 3'b010; rd[1] = 5'd3; data[1] = 32'h33;
    cycle();
    rst_i = 1; valid = 3'b111;
    cycle();
    check("rst_ready", seen_rdy, 3'b000);
    check("rst_wen", RegWEn_o, 1'b0);
    rst_i = 0; rs1_i = 5'd3; rs1_use_i = 1;
    for (int k = 0; k < NREQ; k++) rd[k] = 5'd0;
    cycle();
    check("rst_ptr", seen_rdy, 3'b001);
    check("rst_busy", seen_stall, 1'b0);

    // Randomized traffic; requesters hold their request until granted.
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!valid[k] || last_g == k) begin
          valid[k] = ($urandom_range(0, 3) != 0);
          rd[k]    = 5'($urandom_range(0, 7));
          data[k]  = $urandom;
        end
      end
      rsv_en_i  = ($urandom_range(0, 2) == 0);
      rsv_rd_i  = 5'($urandom_range(0, 7));
      rs1_i     = 5'($urandom_range(0, 7));
      rs2_i     = 5'($urandom_range(0, 7));
      rs1_use_i = 1'($urandom_range(0, 1));
      rs2_use_i = 1'($urandom_range(0, 1));
      rst_i     = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
